// File: rtl/fft_layer_sequencer.sv
// fft_layer_sequencer: steps one FFT pass through NUM_LAYERS butterfly layers with per-layer reset and ping-pong banks.
// Define FFT_SEQ_TIMEOUT_EN to add a per-layer RUN timeout that aborts the pass with a sticky o_err.
module fft_layer_sequencer #(
    parameter int FFT_SIZE       = 8,
    parameter int NUM_LAYERS     = $clog2(FFT_SIZE),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          i_CLK,
    input  logic                          i_RST_n,
    input  logic                          i_start,
    input  logic                          i_layer_done,
    output logic [NUM_LAYERS-1:0]         o_layer_cs,
    output logic                          o_layer_rst,
    output logic [$clog2(NUM_LAYERS)-1:0] o_layer_idx,
    output logic                          o_bank_sel,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err
);
    localparam int IW = $clog2(NUM_LAYERS);

    if (FFT_SIZE < 4 || (FFT_SIZE & (FFT_SIZE - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fft_layer_sequencer: unsupported parameters");
    end

    typedef enum logic [2:0] {
        IDLE, LRST, RUN, NEXT, FIN
`ifdef FFT_SEQ_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t        state, nstate;
    logic [IW-1:0] idx, nidx;
    logic          bank, nbank, nrst, last;

    assign last        = idx == IW'(NUM_LAYERS - 1);
    assign o_layer_idx = idx;
    assign o_bank_sel  = bank;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          timeout;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
`endif

    always_comb begin
        nstate = state;
        nidx   = idx;
        nbank  = bank;
        case (state)
            IDLE: if (i_start) begin
                nstate = LRST;
                nidx   = '0;
                nbank  = 1'b0;
            end
            LRST: nstate = RUN;
            // a done arriving on the cycle the timeout would fire still completes the layer
            RUN: if (i_layer_done) nstate = last ? FIN : NEXT;
`ifdef FFT_SEQ_TIMEOUT_EN
                else if (timeout) nstate = ERR;
`endif
            NEXT: begin
                nstate = LRST;
                nidx   = idx + 1'b1;
                nbank  = ~bank;
            end
            default: nstate = IDLE;
        endcase
        nrst = nstate == LRST
`ifdef FFT_SEQ_TIMEOUT_EN
            || nstate == ERR
`endif
            ;
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state       <= IDLE;
            idx         <= '0;
            bank        <= 1'b0;
            o_layer_cs  <= '0;
            o_layer_rst <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= nstate;
            idx         <= nidx;
            bank        <= nbank;
            o_layer_cs  <= nstate == RUN ? NUM_LAYERS'(1) << nidx : '0;
            o_layer_rst <= nrst;
            o_busy      <= nstate != IDLE;
            o_done      <= nstate == FIN;
        end
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cnt   <= '0;
            o_err <= 1'b0;
        end else begin
            cnt   <= (state == RUN && nstate == RUN) ? cnt + 1'b1 : '0;
            o_err <= nstate == ERR || (o_err && !(state == IDLE && i_start));
        end
    end
`else
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_fft_layer_sequencer.sv
// tb_fft_layer_sequencer: randomized FFT passes checked cycle by cycle against a per-pass expected schedule.
module tb_fft_layer_sequencer;
    localparam int NL  = 3;
    localparam int TMO = 16;
`ifdef FFT_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          i_CLK = 1'b0, i_RST_n = 1'b1, i_start = 1'b0, i_layer_done = 1'b0;
    logic [NL-1:0] o_layer_cs;
    logic [1:0]    o_layer_idx;
    logic          o_layer_rst, o_bank_sel, o_busy, o_done, o_err;

    fft_layer_sequencer #(.FFT_SIZE(8), .TIMEOUT_CYCLES(TMO)) dut (
        .i_CLK(i_CLK), .i_RST_n(i_RST_n), .i_start(i_start), .i_layer_done(i_layer_done),
        .o_layer_cs(o_layer_cs), .o_layer_rst(o_layer_rst), .o_layer_idx(o_layer_idx),
        .o_bank_sel(o_bank_sel), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct packed {
        logic [NL-1:0] cs;
        logic          rst;
        logic [1:0]    idx;
        logic          bank, busy, done, err, din;
    } rec_t;

    rec_t       sched[$];
    rec_t       exp_q[$];
    int         total = 0, bad = 0, cyc = 0, done_cnt = 0;
    int         cs_hist[$], bank_hist[$];
    logic [NL-1:0] prev_cs = '0;
    logic [1:0] m_idx = '0;
    logic       m_bank = 1'b0, m_err = 1'b0;

    function automatic rec_t mk(input logic [NL-1:0] cs, input logic rst, input logic [1:0] idx,
                                input logic bank, input logic busy, input logic done,
                                input logic err, input logic din);
        rec_t r;
        r.cs = cs; r.rst = rst; r.idx = idx; r.bank = bank;
        r.busy = busy; r.done = done; r.err = err; r.din = din;
        return r;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic rec_t idle_rec();
        return mk('0, 1'b0, m_idx, m_bank, 1'b0, 1'b0, m_err, 1'b0);
    endfunction

    // one pass: per layer a reset cycle, the RUN cycles, then a gap cycle (or finish / timeout abort)
    task automatic build(input int r0, input int r1, input int r2);
        int runs[NL];
        int n;
        bit to;
        logic [1:0] li;
        logic lb;
        runs  = '{r0, r1, r2};
        m_err = 1'b0;
        for (int l = 0; l < NL; l++) begin
            li = 2'(l);
            lb = 1'(l % 2);
            to = TO_EN && runs[l] > TMO;
            n  = to ? TMO : runs[l];
            sched.push_back(mk('0, 1'b1, li, lb, 1'b1, 1'b0, 1'b0, rnd()));
            for (int c = 0; c < n; c++)
                sched.push_back(mk(NL'(1 << l), 1'b0, li, lb, 1'b1, 1'b0, 1'b0, (c == n - 1) && !to));
            m_idx  = li;
            m_bank = lb;
            if (to) begin
                sched.push_back(mk('0, 1'b1, li, lb, 1'b1, 1'b0, 1'b1, rnd()));
                m_err = 1'b1;
                return;
            end
            if (l < NL - 1) sched.push_back(mk('0, 1'b0, li, lb, 1'b1, 1'b0, 1'b0, rnd()));
        end
        sched.push_back(mk('0, 1'b0, 2'(NL - 1), 1'((NL - 1) % 2), 1'b1, 1'b1, 1'b0, rnd()));
    endtask

    task automatic start_pass();
        @(posedge i_CLK); #1;
        i_start      = 1'b1;
        i_layer_done = rnd();
        exp_q.push_back(idle_rec());
    endtask

    task automatic play(input int abort_at);
        for (int k = 0; k < sched.size(); k++) begin
            @(posedge i_CLK); #1;
            if (k == abort_at) begin
                i_RST_n = 1'b0; i_start = 1'b0; i_layer_done = 1'b0;
                m_idx = '0; m_bank = 1'b0; m_err = 1'b0;
                exp_q.push_back(idle_rec());
                @(posedge i_CLK); #1;
                i_RST_n = 1'b1;
                exp_q.push_back(idle_rec());
                break;
            end
            i_layer_done = sched[k].din;
            i_start      = rnd();
            exp_q.push_back(sched[k]);
        end
        sched.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_CLK); #1;
            i_start      = 1'b0;
            i_layer_done = rnd();
            exp_q.push_back(idle_rec());
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    always @(negedge i_CLK) begin
        rec_t e;
        cyc++;
        if (o_done) done_cnt++;
        if (o_layer_cs != '0 && prev_cs == '0) begin
            cs_hist.push_back(int'(o_layer_cs));
            bank_hist.push_back(int'(o_bank_sel));
        end
        prev_cs = o_layer_cs;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({o_layer_cs, o_layer_rst, o_layer_idx, o_bank_sel, o_busy, o_done, o_err} !== e[$bits(rec_t)-1:1]) begin
                bad++;
                $display("FAIL cycle %0d outputs: got cs=%b rst=%b idx=%0d bank=%b busy=%b done=%b err=%b want cs=%b rst=%b idx=%0d bank=%b busy=%b done=%b err=%b",
                         cyc, o_layer_cs, o_layer_rst, o_layer_idx, o_bank_sel, o_busy, o_done, o_err,
                         e.cs, e.rst, e.idx, e.bank, e.busy, e.done, e.err);
            end
        end
    end

    initial begin
        int want_cs[NL], want_bank[NL];
        int mx;
        want_cs   = '{1, 2, 4};
        want_bank = '{0, 1, 0};
        #1 i_RST_n = 1'b0;
        repeat (2) begin @(posedge i_CLK); #1; exp_q.push_back(idle_rec()); end
        i_RST_n = 1'b1;
        idle(3);

        // done every RUN cycle: FIN lands 9 cycles after the accepting cycle
        done_cnt = 0;
        start_pass();
        build(1, 1, 1);
        chk("latency_min", sched.size(), 9);
        chk("fin_done_at_9", int'(sched[8].done), 1);
        play(-1);
        idle(2);
        chk("done_count_min", done_cnt, 1);

        // done four cycles after each chip-select rise
        done_cnt = 0; cs_hist.delete(); bank_hist.delete();
        start_pass();
        build(5, 5, 5);
        chk("latency_5", sched.size(), 21);
        play(-1);
        idle(2);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("cs_seq[%0d]", i), i < cs_hist.size() ? cs_hist[i] : -1, want_cs[i]);
            chk($sformatf("bank_seq[%0d]", i), i < bank_hist.size() ? bank_hist[i] : -1, want_bank[i]);
        end
        chk("done_count_5", done_cnt, 1);
        idle(4);

        // reset during the third RUN cycle of layer 2, then a clean pass
        done_cnt = 0;
        start_pass();
        build(2, 2, 6);
        play(11);
        idle(2);
        chk("done_after_abort", done_cnt, 0);
        start_pass();
        build(2, 3, 1);
        play(-1);
        idle(2);
        chk("done_after_restart", done_cnt, 1);

`ifdef FFT_SEQ_TIMEOUT_EN
        start_pass();
        build(3, 40, 2);
        chk("timeout_len", sched.size(), 23);
        play(-1);
        idle(3);
        start_pass();
        build(1, 16, 1);
        play(-1);
        idle(2);
`endif

        mx = TO_EN ? 20 : 8;
        repeat (40) begin
            idle($urandom_range(0, 3));
            start_pass();
            build($urandom_range(1, mx), $urandom_range(1, mx), $urandom_range(1, mx));
            play(-1);
        end
        idle(3);
        @(posedge i_CLK); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
